// File: rtl/dec_scan.sv
// Registered binary-to-one-hot decoder with enable, load strobe and optional scan mode.
// Define DEC_SCAN_EN to build the self-running scan FSM; otherwise direct decode only.
module dec_scan #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  scan_start_i,
  input  logic [DWELL_W-1:0]    dwell_i,
  output logic [(2**SEL_W)-1:0] out_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam logic [0:0]  IDLE  = 1'b0;
`ifdef DEC_SCAN_EN
  localparam int unsigned IDX_W = SEL_W + 1;
  localparam logic [0:0]  SCAN  = 1'b1;
`endif

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] code_q, code_d;
  logic             vld_q, vld_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef DEC_SCAN_EN
  // idx reaching OUT_W marks the closing cycle that emits done.
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dw_q, dw_d;
`else
  logic unused_scan_c;
  assign unused_scan_c = ^{scan_start_i, dwell_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      code_q  <= '0;
      vld_q   <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DEC_SCAN_EN
      idx_q   <= '0;
      cnt_q   <= '0;
      dw_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DEC_SCAN_EN
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dw_q    <= dw_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    vld_d   = vld_q;
    out_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef DEC_SCAN_EN
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dw_d    = dw_q;
`endif
    case (state_q)
      IDLE: begin
        // load has priority over scan_start
        if (load_i) begin
          code_d = sel_i;
          vld_d  = 1'b1;
        end
`ifdef DEC_SCAN_EN
        else if (scan_start_i) begin
          dw_d    = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
`endif
        if (en_i && vld_d) out_d = OUT_W'(1) << code_d;
      end
`ifdef DEC_SCAN_EN
      SCAN: begin
        busy_d = 1'b1;
        if (en_i) begin
          if (idx_q == IDX_W'(OUT_W)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
            code_d  = '0;
            vld_d   = 1'b0;
            idx_d   = '0;
          end else begin
            out_d = OUT_W'(1) << idx_q[SEL_W-1:0];
            if (cnt_q == dw_q - DWELL_W'(1)) begin
              cnt_d = '0;
              idx_d = idx_q + IDX_W'(1);
            end else begin
              cnt_d = cnt_q + DWELL_W'(1);
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed self-checking bench for dec_scan (SEL_W=2, DWELL_W=4).
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst, en, load, scan_start;
  logic [1:0] sel;
  logic [3:0] dwell;
  logic [3:0] out;
  logic       busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  dec_scan #(.SEL_W(2), .DWELL_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .sel_i(sel),
    .scan_start_i(scan_start), .dwell_i(dwell),
    .out_o(out), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b0; sel = '0; scan_start = 1'b0; dwell = '0;
    tick(); tick();
    n_tests++; if (out !== 4'b0000) begin n_fail++; $display("FAIL reset_out: got %b want 0000", out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    tick();
    n_tests++; if (out !== 4'b0000) begin n_fail++; $display("FAIL post_reset_out: got %b want 0000", out); end
  endtask

  task automatic test_direct();
    logic [3:0] exp_t [4];
    exp_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int s = 0; s < 4; s++) begin
      load = 1'b1; sel = 2'(s);
      tick();
      load = 1'b0;
      n_tests++;
      if (out !== exp_t[s]) begin n_fail++; $display("FAIL direct_sel%0d: got %b want %b", s, out, exp_t[s]); end
    end
    sel = 2'd0;
    tick();
    n_tests++; if (out !== 4'b1000) begin n_fail++; $display("FAIL direct_hold: got %b want 1000", out); end
  endtask

  task automatic test_en_gating();
    load = 1'b1; sel = 2'd2;
    tick();
    load = 1'b0;
    n_tests++; if (out !== 4'b0100) begin n_fail++; $display("FAIL en_load: got %b want 0100", out); end
    en = 1'b0;
    tick();
    n_tests++; if (out !== 4'b0000) begin n_fail++; $display("FAIL en_off: got %b want 0000", out); end
    tick();
    n_tests++; if (out !== 4'b0000) begin n_fail++; $display("FAIL en_off_hold: got %b want 0000", out); end
    en = 1'b1;
    tick();
    n_tests++; if (out !== 4'b0100) begin n_fail++; $display("FAIL en_on: got %b want 0100", out); end
    en = 1'b0; load = 1'b1; sel = 2'd1;
    tick();
    load = 1'b0;
    n_tests++; if (out !== 4'b0000) begin n_fail++; $display("FAIL en_off_load: got %b want 0000", out); end
    en = 1'b1;
    tick();
    n_tests++; if (out !== 4'b0010) begin n_fail++; $display("FAIL en_on_after_load: got %b want 0010", out); end
  endtask

  task automatic test_load_precedence();
    load = 1'b1; scan_start = 1'b1; sel = 2'd3; dwell = 4'd3;
    tick();
    load = 1'b0; scan_start = 1'b0;
    n_tests++; if (out !== 4'b1000) begin n_fail++; $display("FAIL prec_out: got %b want 1000", out); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prec_busy: got %b want 0", busy); end
    n_tests++; if (out !== 4'b1000) begin n_fail++; $display("FAIL prec_hold: got %b want 1000", out); end
  endtask

`ifdef DEC_SCAN_EN
  task automatic test_full_scan();
    logic [3:0] eo;
    logic       eb, ed;
    dwell = 4'd3; scan_start = 1'b1;
    tick();
    scan_start = 1'b0; dwell = 4'd1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL scan_edge0_busy: got %b want 0", busy); end
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c <= 12) begin eo = 4'(4'd1 << ((c - 1) / 3)); eb = 1'b1; ed = 1'b0; end
      else if (c == 13) begin eo = 4'b0000; eb = 1'b0; ed = 1'b1; end
      else begin eo = 4'b0000; eb = 1'b0; ed = 1'b0; end
      n_tests++;
      if ({out, busy, done} !== {eo, eb, ed}) begin
        n_fail++;
        $display("FAIL scan_c%0d: got out=%b busy=%b done=%b want out=%b busy=%b done=%b", c, out, busy, done, eo, eb, ed);
      end
    end
  endtask

  task automatic test_dwell_zero();
    dwell = 4'd0; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_tests++;
      if (c <= 4) begin
        if (out !== 4'(4'd1 << (c - 1)) || done !== 1'b0) begin
          n_fail++; $display("FAIL dwell0_c%0d: got out=%b done=%b", c, out, done);
        end
      end else if (out !== 4'b0000 || done !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL dwell0_done: got out=%b busy=%b done=%b want 0000 0 1", out, busy, done);
      end
    end
  endtask

  task automatic test_load_during_scan();
    dwell = 4'd3; scan_start = 1'b1;
    tick();
    scan_start = 1'b0; load = 1'b1; sel = 2'd1;
    tick();
    load = 1'b0;
    n_tests++; if (out !== 4'b0001) begin n_fail++; $display("FAIL ld_scan_e1: got %b want 0001", out); end
    for (int c = 2; c <= 13; c++) tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ld_scan_done: got %b want 1", done); end
    tick();
    n_tests++; if (out !== 4'b0000) begin n_fail++; $display("FAIL ld_scan_after: got %b want 0000", out); end
  endtask

  task automatic test_back_to_back();
    dwell = 4'd0; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
    dwell = 4'd2; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    n_tests++; if ({out, busy, done} !== 6'b0000_0_0) begin n_fail++; $display("FAIL b2b_restart: got %b%b%b want 000000", out, busy, done); end
    tick();
    n_tests++; if (out !== 4'b0001 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_e1: got out=%b busy=%b want 0001 1", out, busy); end
    tick(); tick();
    n_tests++; if (out !== 4'b0010) begin n_fail++; $display("FAIL b2b_e3: got %b want 0010", out); end
    for (int c = 4; c <= 9; c++) tick();
    n_tests++; if (done !== 1'b1 || out !== 4'b0000) begin n_fail++; $display("FAIL b2b_second_done: got done=%b out=%b want 1 0000", done, out); end
  endtask

  task automatic test_pause();
    dwell = 4'd2; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (out !== 4'b0010) begin n_fail++; $display("FAIL pause_e3: got %b want 0010", out); end
    en = 1'b0;
    tick();
    n_tests++; if (out !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL pause_e4: got out=%b busy=%b want 0000 1", out, busy); end
    tick(); tick();
    en = 1'b1;
    tick();
    n_tests++; if (out !== 4'b0010) begin n_fail++; $display("FAIL pause_resume: got %b want 0010", out); end
    for (int c = 8; c <= 11; c++) tick();
    n_tests++; if (done !== 1'b0 || out !== 4'b1000) begin n_fail++; $display("FAIL pause_e11: got done=%b out=%b want 0 1000", done, out); end
    tick();
    n_tests++; if (done !== 1'b1 || out !== 4'b0000) begin n_fail++; $display("FAIL pause_done: got done=%b out=%b want 1 0000", done, out); end
  endtask

  task automatic test_reset_mid_scan();
    logic seen_done;
    dwell = 4'd3; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if ({out, busy, done} !== 6'b0000_0_0) begin n_fail++; $display("FAIL rst_mid: got out=%b busy=%b done=%b want 0000 0 0", out, busy, done); end
    seen_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got activity=%b want 0", seen_done); end
  endtask
`else
  task automatic test_no_scan();
    load = 1'b1; sel = 2'd1;
    tick();
    load = 1'b0; scan_start = 1'b1; dwell = 4'd5;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if ({out, busy, done} !== 6'b0010_0_0) begin
        n_fail++; $display("FAIL noscan_c%0d: got out=%b busy=%b done=%b want 0010 0 0", c, out, busy, done);
      end
    end
    scan_start = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_direct();
    test_en_gating();
    test_load_precedence();
`ifdef DEC_SCAN_EN
    test_full_scan();
    test_dwell_zero();
    test_load_during_scan();
    test_back_to_back();
    test_pause();
    test_reset_mid_scan();
`else
    test_no_scan();
`endif
    test_direct();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
